// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte push handshake between a producer and the UART transmit FIFO
interface uart_tx_fifo_if;
    logic [7:0] Data_in;
    logic       Send;
    logic       Ready;

    modport master (
        output Data_in,
        output Send,
        input  Ready
    );

    modport slave (
        input  Data_in,
        input  Send,
        output Ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small FIFO; define UART_TX_PARITY_EN for an even-parity bit
module uart_tx_fifo #(
    parameter int UBRR       = 5207,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    uart_tx_fifo_if.slave  bus,
    output logic           TX,
    output logic           Busy,
    output logic           Empty,
    output logic           Overflow
);

    localparam int CNT_W  = (UBRR < 1) ? 1 : $clog2(UBRR + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(UBRR);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic [7:0]          mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic ready;
    logic push;
    logic pop;
    logic bit_end;

    // Ready looks only at the pre-edge count, so a full FIFO refuses a byte even on a pop cycle.
    assign ready   = (count_q != FULL_CNT);
    assign push    = bus.Send && ready;
    assign pop     = (state_q == S_IDLE) && (count_q != '0);
    assign bit_end = (baud_q == BAUD_LAST);

    assign bus.Ready = ready;
    assign TX        = tx_q;
    assign Busy      = (state_q != S_IDLE);
    assign Empty     = (count_q == '0);
    assign Overflow  = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (bus.Send && !ready);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d  = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem[rd_ptr_q];
`endif
                    baud_d   = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // The line level is registered from the current state, so TX trails the state by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.Data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a queue model and a line receiver
module tb_uart_tx_fifo;

    localparam int UBRR  = 3;
    localparam int DEPTH = 4;
    localparam int BITCLK = UBRR + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BITCLK;

    logic Clk = 1'b0;
    logic Reset_n;
    logic TX, Busy, Empty, Overflow;

    uart_tx_fifo_if bus_if ();

    uart_tx_fifo #(.UBRR(UBRR), .FIFO_DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .bus      (bus_if.slave),
        .TX       (TX),
        .Busy     (Busy),
        .Empty    (Empty),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending bytes as a queue, transmitter as "free again at cycle X".
    int         cyc = 0;
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         m_next_pop = 0;
    int         m_busy_end = 0;
    bit         m_ovf = 0;
    bit         check_en = 0;

    always @(posedge Clk) begin
        int pre;
        cyc++;
        if (!Reset_n) begin
            mq.delete();
            sb.delete();
            m_next_pop = 0;
            m_busy_end = 0;
            m_ovf = 0;
        end else begin
            pre = mq.size();
            if (bus_if.Send && pre >= DEPTH) m_ovf = 1;
            if (cyc >= m_next_pop && pre > 0) begin
                sb.push_back(mq.pop_front());
                m_busy_end = cyc + FRAME;
                m_next_pop = cyc + FRAME + 1;
            end
            if (bus_if.Send && pre < DEPTH) mq.push_back(bus_if.Data_in);
        end
    end

    always @(negedge Clk) begin
        if (check_en) begin
            chk("ready", 32'(bus_if.Ready), 32'(mq.size() < DEPTH));
            chk("empty", 32'(Empty), 32'(mq.size() == 0));
            chk("busy", 32'(Busy), 32'(cyc < m_busy_end));
            chk("overflow", 32'(Overflow), 32'(m_ovf));
        end
    end

    // Line receiver: samples each bit in the middle of its BITCLK-cycle window.
    bit          mon_act = 0;
    int          mon_t = 0;
    logic [10:0] mon_bits;
    int          starts[$];

    always @(negedge Clk) begin
        int idx;
        logic [7:0] rx;
        if (!Reset_n) begin
            mon_act = 0;
        end else if (!mon_act) begin
            if (TX === 1'b0) begin
                mon_act = 1;
                mon_t = 0;
                if (starts.size() > 0)
                    chk("frame_gap_min", 32'((cyc - starts[$]) >= FRAME + 1), 32'd1);
                starts.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t % BITCLK == BITCLK / 2) begin
                idx = mon_t / BITCLK;
                mon_bits[idx] = TX;
                if (idx == NB - 1) begin
                    mon_act = 0;
                    rx = mon_bits[8:1];
                    chk("start_bit", 32'(mon_bits[0]), 32'd0);
                    chk("stop_bit", 32'(mon_bits[NB-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", 32'(mon_bits[9]), 32'(^rx));
`endif
                    if (sb.size() == 0) begin
                        chk("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
                    end else begin
                        chk("rx_byte", 32'(rx), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.Send = 1'b1;
        bus_if.Data_in = b;
        @(negedge Clk);
        bus_if.Send = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        Reset_n = 1'b0;
        bus_if.Send = 1'b0;
        bus_if.Data_in = 8'h00;
        idle_cycles(3);
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_ready", 32'(bus_if.Ready), 32'd1);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        Reset_n = 1'b1;
        check_en = 1;
        idle_cycles(2);

        // Single byte: latency and frame length.
        send_byte(8'h55);
        chk("lat_tx_n", 32'(TX), 32'd1);
        chk("lat_empty_n", 32'(Empty), 32'd0);
        @(posedge Clk); #1;
        chk("lat_tx_n1", 32'(TX), 32'd1);
        chk("lat_busy_n1", 32'(Busy), 32'd1);
        chk("lat_empty_n1", 32'(Empty), 32'd1);
        @(posedge Clk); #1;
        chk("lat_tx_n2", 32'(TX), 32'd0);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (!Busy) break;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'(FRAME));
        idle_cycles(10);

        // Back-to-back frames.
        bus_if.Send = 1'b1;
        bus_if.Data_in = 8'hA5;
        @(negedge Clk);
        bus_if.Data_in = 8'h3C;
        @(negedge Clk);
        bus_if.Send = 1'b0;
        idle_cycles(2 * FRAME + 20);
        chk("b2b_gap", 32'(starts[starts.size()-1] - starts[starts.size()-2]), 32'(FRAME + 1));

        // Full FIFO and sticky overflow.
        send_byte(8'h99);
        idle_cycles(5);
        for (int i = 1; i <= 6; i++) begin
            bus_if.Send = 1'b1;
            bus_if.Data_in = 8'(i);
            @(negedge Clk);
            if (i == 3) chk("full_ready3", 32'(bus_if.Ready), 32'd1);
            if (i == 4) chk("full_ready4", 32'(bus_if.Ready), 32'd0);
        end
        bus_if.Send = 1'b0;
        chk("ovf_set", 32'(Overflow), 32'd1);
        idle_cycles(6 * (FRAME + 1));
        chk("ovf_sticky", 32'(Overflow), 32'd1);
        chk("ovf_drained", 32'(Empty), 32'd1);

        // Push and pop on the same edge at count 1.
        bus_if.Send = 1'b1;
        bus_if.Data_in = 8'h11;
        @(negedge Clk);
        bus_if.Data_in = 8'h22;
        @(negedge Clk);
        bus_if.Send = 1'b0;
        chk("pushpop_empty", 32'(Empty), 32'd0);
        chk("pushpop_busy", 32'(Busy), 32'd1);
        idle_cycles(2 * FRAME + 20);

        // Asynchronous reset in the middle of a frame.
        send_byte(8'h5A);
        idle_cycles(15);
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(TX), 32'd1);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_empty", 32'(Empty), 32'd1);
        chk("mid_rst_ready", 32'(bus_if.Ready), 32'd1);
        chk("mid_rst_ovf", 32'(Overflow), 32'd0);
        idle_cycles(3);
        Reset_n = 1'b1;
        idle_cycles(3 * FRAME);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus_if.Send = ($urandom_range(0, 9) == 0);
            bus_if.Data_in = 8'($urandom);
            @(negedge Clk);
        end
        bus_if.Send = 1'b0;
        idle_cycles((DEPTH + 2) * (FRAME + 1));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("rx_idle", 32'(mon_act), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
